cfg_chain_loader: RTL and testbench
===================================

# cfg_chain_loader

Configuration-chain loader for the fabric tile. It accepts configuration words from the host side over a valid/ready stream and serializes them, LSB first, into the daisy-chained slice configuration shift register of `CHAIN_LEN` bits. It then issues a single-cycle latch pulse to commit the configuration. Bits returned from the chain end are collected into readback words so the previous configuration can be verified.

## Interface
Parameters:
- `WORD_W`, 32, host word width (≥2).
- `CHAIN_LEN`, 160, total configuration bits in the chain (≥1). The number of words per load is `NWORDS = ceil(CHAIN_LEN/WORD_W)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `abort`  in  1  cancel the current load; wins over `start`.
- `busy`  out  1  high in any non-IDLE state.
- `done`  out  1  one-cycle pulse after a completed load.
- `wr_valid`  in  1  host word valid.
- `wr_ready`  out  1  loader can take a word.
- `wr_data`  in  WORD_W  host configuration word; bit 0 is shifted first.
- `cfg_shift_en`  out  1  chain shift enable (drives slice `cen`).
- `cfg_shift_data`  out  1  bit into the chain head (slice `shift_in`).
- `cfg_set`  out  1  latch/commit pulse (slice `set_in`).
- `cfg_shift_return`  in  1  bit from the chain tail (slice `shift_out`).
- `rd_valid`  out  1  one-cycle pulse, readback word valid.
- `rd_data`  out  WORD_W  readback word; bit 0 is the first bit returned.

## Operation
- Reset values: all outputs are 0. The FSM is in IDLE and all counters are 0.
- FSM states: IDLE, LOAD, LATCH, FINISH.
  - IDLE→LOAD on `start` when `abort` is low.
  - LOAD→LATCH after shift number `CHAIN_LEN`.
  - LATCH→FINISH unconditionally.
  - FINISH→IDLE unconditionally.
  - Any non-IDLE state →IDLE on `abort`.
- The word buffer is one word register plus a bit index `0..WORD_W-1`.
- `wr_ready` is high in LOAD when either condition holds, and fewer than `NWORDS` words have been accepted:
  - the buffer is empty, or
  - the buffer is shifting its last valid bit this cycle.
- Word handshake: `wr_valid && wr_ready`.
- Each cycle with a buffered bit:
  - `cfg_shift_en=1`.
  - `cfg_shift_data` = the buffer bit at the current index.
  - The bit index and the global bit counter (`0..CHAIN_LEN`) advance.
- With no buffered bit, `cfg_shift_en=0` and `cfg_shift_data=0`. The chain holds its state.
- Last word: only `CHAIN_LEN-(NWORDS-1)*WORD_W` low bits are shifted. The upper bits are discarded.
- Readback:
  - On every shift cycle, `cfg_shift_return` is sampled into the readback register at the position equal to the readback count.
  - After `WORD_W` samples, or after the final chain bit, `rd_valid` pulses for one cycle with `rd_data`. Unfilled MSBs of a partial word are 0.
  - There is no backpressure; the consumer must take the word in that cycle.
- LATCH: `cfg_set=1` and `cfg_shift_en=0` for exactly one cycle.
- FINISH: `done=1` for one cycle. `busy` is still high in FINISH.
- Abort:
  - The next cycle is IDLE, with `cfg_shift_en`, `cfg_set` and `wr_ready` at 0.
  - `done` and `cfg_set` are never asserted for that load.
  - A partial readback word is dropped.
  - The word counter, bit counter and buffer are cleared.
- `start` while busy is ignored. Words offered outside LOAD are not accepted.

## Timing
- Handshake at edge N: the first bit of that word is driven in cycle N+1.
- With `wr_valid` held high, shifting is gapless: exactly `CHAIN_LEN` consecutive `cfg_shift_en` cycles.
- The final shift occurs in cycle S. `cfg_set` is high in S+1, `done` in S+2, and `busy` is low in S+3.
- `rd_valid` is asserted in the cycle after the shift that completes the word.
- `rd_valid` for the final partial word is asserted in S+1, coincident with `cfg_set`.
- Async reset takes effect immediately; all outputs go to 0 regardless of state.
- All outputs are registered. No combinational path exists from inputs to `cfg_*` outputs.

## Structure
- Shared package `cfg_loader_pkg`:
  - state enum `cfg_state_t`;
  - helper functions `nwords(CHAIN_LEN,WORD_W)` and `cnt_w(n)` (counter width = `$clog2(n+1)`).
- Sub-module `cfg_word_serializer`: word buffer, bit index, valid-bit count and the ready logic. The top module holds the FSM, global counters and readback packing.

## Test plan
Bench parameters: `WORD_W=4`, `CHAIN_LEN=10`.
- Gapless load with words 0x5, 0xA, 0x3 → `cfg_shift_data` = 1,0,1,0,0,1,0,1,1,1 over 10 consecutive enable cycles; `cfg_set` in the 11th cycle, `done` in the 12th; only 3 handshakes occur.
- Host stalls 3 cycles between words 1 and 2 → `cfg_shift_en` is low for exactly those 3 cycles; the total is still 10 shifts and the data sequence is unchanged.
- Readback with `cfg_shift_return` driven by a 10-bit chain model preloaded with 0x2B5 → `rd_data` = 0x5, 0xB, 0x2 with 3 `rd_valid` pulses; the last pulse coincides with `cfg_set`.
- `abort` after 5 shifts → IDLE the next cycle; no `cfg_set` or `done`, and only one `rd_valid` seen. A following `start` and full load completes normally.
- `rst` asserted low mid-LOAD, asynchronously and between clock edges → all outputs are 0 immediately. After release, a `start` load works.
- `start` pulsed during LOAD is ignored. A 4th word offered after the 3rd is not accepted (`wr_ready=0`). `start` and `abort` together in IDLE → `busy` stays 0.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared FSM state type and sizing helpers for the config-chain loader
package cfg_loader_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, LATCH, FINISH} cfg_state_t;
   function automatic int nwords(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: one-word buffer that feeds the chain one bit per cycle, LSB first
//   clr_i        drop the buffered word and bit position
//   room_i       loader is in LOAD and still owes words
//   last_word_i  the next accepted word is the last one (only its low bits are used)
//   wr_*         host word stream; wr_ready_o/accept_o report the handshake
//   shift_o      a buffered bit is being shifted this cycle; bit_o is that bit
module cfg_word_serializer import cfg_loader_pkg::*; #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 160
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              room_i,
   input  logic              last_word_i,
   input  logic              wr_valid_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic              wr_ready_o,
   output logic              accept_o,
   output logic              shift_o,
   output logic              bit_o
);
   localparam int NW   = nwords(CHAIN_LEN, WORD_W);
   localparam int LAST = CHAIN_LEN - (NW - 1) * WORD_W;
   localparam int BW   = cnt_w(WORD_W);
   logic [WORD_W-1:0] data_q, data_d;
   logic [BW-1:0]     idx_q, idx_d, nbits_q, nbits_d;
   logic              last_bit;
   // nbits_q == 0 means empty; the word is shifted right so bit 0 is always the current bit
   assign shift_o    = nbits_q != '0;
   assign last_bit   = shift_o && idx_q == nbits_q - BW'(1);
   // refilling on the last bit keeps a held-valid host gapless
   assign wr_ready_o = room_i && (!shift_o || last_bit);
   assign accept_o   = wr_valid_i && wr_ready_o;
   assign bit_o      = shift_o && data_q[0];
   always_comb begin
      data_d  = clr_i ? '0 : accept_o ? wr_data_i : shift_o ? data_q >> 1 : data_q;
      idx_d   = (clr_i || accept_o || last_bit) ? '0 : shift_o ? idx_q + BW'(1) : idx_q;
      nbits_d = clr_i ? '0 : accept_o ? BW'(last_word_i ? LAST : WORD_W) : last_bit ? '0 : nbits_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         data_q  <= '0;
         idx_q   <= '0;
         nbits_q <= '0;
      end else begin
         data_q  <= data_d;
         idx_q   <= idx_d;
         nbits_q <= nbits_d;
      end
endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: loads host words serially into the slice config chain, latches them, and packs readback
//   clk/rst            clock, async active-low reset
//   start/abort/busy/done   load control and status
//   wr_valid/wr_ready/wr_data   host word stream
//   cfg_shift_en/cfg_shift_data/cfg_set/cfg_shift_return   chain interface
//   rd_valid/rd_data   readback word pulse
module cfg_chain_loader import cfg_loader_pkg::*; #(
   parameter int WORD_W    = 32,
   parameter int CHAIN_LEN = 160
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WORD_W-1:0] wr_data,
   output logic              cfg_shift_en,
   output logic              cfg_shift_data,
   output logic              cfg_set,
   input  logic              cfg_shift_return,
   output logic              rd_valid,
   output logic [WORD_W-1:0] rd_data
);
   localparam int NW = nwords(CHAIN_LEN, WORD_W);
   localparam int WW = cnt_w(NW);
   localparam int BB = cnt_w(CHAIN_LEN);
   localparam int RB = cnt_w(WORD_W);
   cfg_state_t        state_q, state_d;
   logic [WW-1:0]     words_q, words_d;
   logic [BB-1:0]     bits_q, bits_d;
   logic [RB-1:0]     rb_cnt_q, rb_cnt_d;
   logic [WORD_W-1:0] rb_q, rb_d, rd_data_q, rd_data_d, rb_new;
   logic              rd_valid_q, rd_valid_d;
   logic              run, room, accept, shift, bit_v, final_bit, word_full;
   // run low clears every counter and the buffer, so abort and leaving LOAD share one path
   assign run       = state_q == LOAD && !abort;
   assign room      = state_q == LOAD && words_q != WW'(NW);
   assign final_bit = shift && bits_q == BB'(CHAIN_LEN - 1);
   assign word_full = rb_cnt_q == RB'(WORD_W - 1) || final_bit;
   assign rb_new    = rb_q | (WORD_W'(cfg_shift_return) << rb_cnt_q);
   cfg_word_serializer #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) u_ser (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (!run),
      .room_i      (room),
      .last_word_i (words_q == WW'(NW - 1)),
      .wr_valid_i  (wr_valid),
      .wr_data_i   (wr_data),
      .wr_ready_o  (wr_ready),
      .accept_o    (accept),
      .shift_o     (shift),
      .bit_o       (bit_v)
   );
   always_comb begin
      case (state_q)
         IDLE:    state_d = start ? LOAD : IDLE;
         LOAD:    state_d = final_bit ? LATCH : LOAD;
         LATCH:   state_d = FINISH;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
      words_d    = run ? words_q + WW'(accept) : '0;
      bits_d     = run ? bits_q + BB'(shift) : '0;
      rb_d       = !run ? '0 : !shift ? rb_q : word_full ? '0 : rb_new;
      rb_cnt_d   = !run ? '0 : !shift ? rb_cnt_q : word_full ? '0 : rb_cnt_q + RB'(1);
      rd_valid_d = run && shift && word_full;
      rd_data_d  = rd_valid_d ? rb_new : rd_data_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q    <= IDLE;
         words_q    <= '0;
         bits_q     <= '0;
         rb_q       <= '0;
         rb_cnt_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         words_q    <= words_d;
         bits_q     <= bits_d;
         rb_q       <= rb_d;
         rb_cnt_q   <= rb_cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   assign busy           = state_q != IDLE;
   assign done           = state_q == FINISH;
   assign cfg_set        = state_q == LATCH;
   assign cfg_shift_en   = shift;
   assign cfg_shift_data = bit_v;
   assign rd_valid       = rd_valid_q;
   assign rd_data        = rd_data_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: directed bench for cfg_chain_loader with a 10-bit chain model
module tb_cfg_chain_loader;
   logic       clk = 0, rst = 0, start = 0, abort = 0, wr_valid = 0;
   logic [3:0] wr_data = 0;
   logic       busy, done, wr_ready, cfg_shift_en, cfg_shift_data, cfg_set, cfg_shift_return, rd_valid;
   logic [3:0] rd_data;
   logic [9:0] chain, preload_val = 10'h2B5;
   logic       preload = 0;
   always #5 clk = ~clk;
   cfg_chain_loader #(.WORD_W(4), .CHAIN_LEN(10)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .cfg_shift_en(cfg_shift_en), .cfg_shift_data(cfg_shift_data), .cfg_set(cfg_set),
      .cfg_shift_return(cfg_shift_return), .rd_valid(rd_valid), .rd_data(rd_data)
   );
   // chain model: head enters at bit 9, tail returns bit 0
   always @(posedge clk)
      if (preload) chain <= preload_val;
      else if (cfg_shift_en) chain <= {cfg_shift_data, chain[9:1]};
   assign cfg_shift_return = chain[0];
   int checks = 0, errors = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   int cyc = 0, n_shift, n_gap, n_set, n_done, n_hs, first_cyc, last_cyc, set_cyc, done_cyc, idle_cyc, hs0_cyc;
   logic [9:0]  bits;
   logic [3:0]  rdw[$];
   int          rdc[$];
   logic [3:0]  words[4] = '{4'h5, 4'hA, 4'h3, 4'hF};
   int          wp, n_offer, stall_at, stall_left;
   logic        host_on = 0;
   task automatic clear_log();
      n_shift = 0; n_gap = 0; n_set = 0; n_done = 0; n_hs = 0; bits = '0;
      first_cyc = -1; last_cyc = -1; set_cyc = -1; done_cyc = -1; idle_cyc = -1; hs0_cyc = -1;
      rdw.delete(); rdc.delete(); wp = 0; stall_left = 0;
   endtask
   // sample outputs mid-cycle, then drive the host for the coming edge
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (cfg_shift_en) begin
         if (n_shift < 10) bits[n_shift[3:0]] = cfg_shift_data;
         if (n_shift == 0) first_cyc = cyc;
         n_shift++;
         last_cyc = cyc;
      end else if (n_shift > 0 && n_shift < 10) n_gap++;
      if (cfg_set) begin n_set++; set_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (!busy && n_done > 0 && idle_cyc < 0) idle_cyc = cyc;
      if (rd_valid) begin rdw.push_back(rd_data); rdc.push_back(cyc); end
      if (host_on && stall_left > 0 && wr_ready) begin
         stall_left--;
         wr_valid = 0;
      end else begin
         wr_valid = host_on && wp < n_offer;
         wr_data  = words[wp < 4 ? wp[1:0] : 2'd0];
      end
      if (wr_valid && wr_ready) begin
         if (n_hs == 0) hs0_cyc = cyc;
         n_hs++;
         wp++;
         if (wp == stall_at) stall_left = 3;
      end
   endtask
   task automatic run_load(input int st_at, input int offer, input bit mid_start);
      clear_log();
      stall_at = st_at; n_offer = offer; host_on = 1;
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 60 && idle_cyc < 0; i++) begin
         tick();
         start = mid_start && n_shift == 6;
      end
      start = 0; host_on = 0; wr_valid = 0;
      check("load_timeout", idle_cyc >= 0, 1);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("reset_outs", {busy, done, wr_ready, cfg_shift_en, cfg_shift_data, cfg_set, rd_valid, rd_data}, 0);
      rst = 1; preload = 1;
      tick();
      preload = 0;
      // gapless load, readback of preloaded 0x2B5
      run_load(0, 3, 0);
      check("t1_bits", bits, 10'h3A5);
      check("t1_nshift", n_shift, 10);
      check("t1_gap", n_gap, 0);
      check("t1_hs", n_hs, 3);
      check("t1_first_lat", first_cyc - hs0_cyc, 1);
      check("t1_set_lat", set_cyc - last_cyc, 1);
      check("t1_done_lat", done_cyc - last_cyc, 2);
      check("t1_idle_lat", idle_cyc - last_cyc, 3);
      check("t1_nset", n_set, 1);
      check("t1_rd_n", rdw.size(), 3);
      check("t1_rd_data", {rdw[0], rdw[1], rdw[2]}, 12'h5B2);
      check("t1_rd0_cyc", rdc[0] - first_cyc, 4);
      check("t1_rd_last_set", rdc[2] - set_cyc, 0);
      // 3-cycle host stall after word 1, extra 4th word, start pulsed mid-load
      run_load(1, 4, 1);
      check("t2_bits", bits, 10'h3A5);
      check("t2_nshift", n_shift, 10);
      check("t2_gap", n_gap, 3);
      check("t2_hs", n_hs, 3);
      check("t2_rd_data", {rdw[0], rdw[1], rdw[2]}, 12'h5A3);
      check("t2_set_done", {n_set[3:0], n_done[3:0]}, 8'h11);
      check("t2_set_lat", set_cyc - last_cyc, 1);
      // abort after 5 shifts
      clear_log();
      stall_at = 0; n_offer = 3; host_on = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 40 && n_shift < 5; i++) tick();
      abort = 1;
      tick();
      abort = 0;
      check("t3_idle_next", {busy, cfg_shift_en, cfg_set, wr_ready}, 0);
      host_on = 0;
      repeat (5) tick();
      check("t3_nshift", n_shift, 5);
      check("t3_no_set_done", n_set + n_done, 0);
      check("t3_rd_n", rdw.size(), 1);
      check("t3_rd0", rdw[0], 4'h5);
      // full load after abort; chain now holds 0x0BD
      run_load(0, 3, 0);
      check("t4_bits", bits, 10'h3A5);
      check("t4_set_done", {n_set[3:0], n_done[3:0]}, 8'h11);
      check("t4_rd_data", {rdw[0], rdw[1], rdw[2]}, 12'hDB0);
      // async reset between edges mid-load
      clear_log();
      stall_at = 0; n_offer = 3; host_on = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 40 && n_shift < 3; i++) tick();
      check("t5_pre_busy", {busy, cfg_shift_en}, 2'b11);
      #2 rst = 0;
      #1 check("t5_async_rst", {busy, done, wr_ready, cfg_shift_en, cfg_shift_data, cfg_set, rd_valid, rd_data}, 0);
      host_on = 0; wr_valid = 0;
      @(negedge clk);
      rst = 1;
      run_load(0, 3, 0);
      check("t5_bits", bits, 10'h3A5);
      check("t5_set_done", {n_set[3:0], n_done[3:0]}, 8'h11);
      // start together with abort in IDLE
      start = 1; abort = 1;
      tick();
      start = 0; abort = 0;
      check("t6_busy0", busy, 0);
      tick();
      check("t6_busy1", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
